// File: rtl/sw_debouncer_pkg.sv
// Shared types and constants for the switch debouncer: FSM state encoding,
// default parameter values and a constant-foldable ceil(log2) helper.
package sw_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_e;

  localparam int unsigned SYNC_STAGES_DEFAULT     = 32'd2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd2000000;

  // Smallest r with 2**r >= value; used to size the qualification counter.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      result = ((64'd1 << i) < {32'd0, value}) ? (i + 1) : result;
    end
    return result;
  endfunction

endpackage

// File: rtl/sw_debouncer_bit_synchronizer.sv
// bit_synchronizer: N-stage flip-flop chain bringing an asynchronous level
// into the clk_in domain; reusable for any slow board input.
module bit_synchronizer #(
  parameter int unsigned stages_p = 32'd2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [stages_p-1:0] sync_q;
  logic [stages_p-1:0] sync_d;

  // Shift the raw input into the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[stages_p-2:0], d};
  end

  // Chain registers, cleared by synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= {stages_p{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[stages_p-1];

endmodule

// File: rtl/sw_debouncer.sv
// Switch debouncer: synchronizes sw_in, qualifies each new level over
// debounce_cycles_p stable cycles, and emits registered edge pulses.
// Build option SW_DEBOUNCER_TOGGLE_EN turns sw_out into a push-button toggle.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int unsigned sync_stages_p     = SYNC_STAGES_DEFAULT,
  parameter int unsigned debounce_cycles_p = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned      CNT_W    = clog2_f(debounce_cycles_p + 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles_p - 32'd1);

  logic sync_s;

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_out_q, sw_out_d;
  logic             sw_rise_q, sw_rise_d;
  logic             sw_fall_q, sw_fall_d;
  logic             accept_rise_s;
  logic             accept_fall_s;

  bit_synchronizer #(
    .stages_p (sync_stages_p)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sw_in),
    .q      (sync_s)
  );

  // Qualification FSM: any disagreeing sample restarts from the stable state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept_rise_s = 1'b0;
    accept_fall_s = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        cnt_d = CNT_ZERO;
        if (sync_s) begin
          state_d = WAIT_HIGH;
        end else begin
          state_d = STABLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_d = STABLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = STABLE_HIGH;
          cnt_d         = CNT_ZERO;
          accept_rise_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        cnt_d = CNT_ZERO;
        if (!sync_s) begin
          state_d = WAIT_LOW;
        end else begin
          state_d = STABLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_d = STABLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = STABLE_LOW;
          cnt_d         = CNT_ZERO;
          accept_fall_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output next-state: level follower by default, toggle on rise in button mode.
  always_comb begin
    sw_rise_d = accept_rise_s;
    sw_fall_d = accept_fall_s;
`ifdef SW_DEBOUNCER_TOGGLE_EN
    if (accept_rise_s) begin
      sw_out_d = ~sw_out_q;
    end else begin
      sw_out_d = sw_out_q;
    end
`else
    if (accept_rise_s) begin
      sw_out_d = 1'b1;
    end else if (accept_fall_s) begin
      sw_out_d = 1'b0;
    end else begin
      sw_out_d = sw_out_q;
    end
`endif
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= STABLE_LOW;
      cnt_q     <= CNT_ZERO;
      sw_out_q  <= 1'b0;
      sw_rise_q <= 1'b0;
      sw_fall_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_out_q  <= sw_out_d;
      sw_rise_q <= sw_rise_d;
      sw_fall_q <= sw_fall_d;
    end
  end

  assign sw_out  = sw_out_q;
  assign sw_rise = sw_rise_q;
  assign sw_fall = sw_fall_q;

endmodule
